// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues sequential PCs to a variable-latency imem and
// buffers {pc, ir} pairs for decode; redirects flush the queue and squash in-flight fetches.
module ifetch_queue #(
    parameter int                    WORD_WIDTH      = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bubble,
    input  logic [1:0]            pc_sel,
    input  logic [WORD_WIDTH-1:0] jal_bxx_tgt,
    input  logic [WORD_WIDTH-1:0] jalr_tgt,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WORD_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [31:0]           ir
);

    localparam int QAW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);
    localparam logic [TAW-1:0]        TAG_LAST   = TAW'(MAX_OUTSTANDING - 1);

    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [QAW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]         out_q, out_d, drop_q, drop_d;
    logic [TAW-1:0]        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic                  run_q;

    logic [WORD_WIDTH-1:0] q_pc_q [DEPTH];
    logic [31:0]           q_ir_q [DEPTH];
    logic [WORD_WIDTH-1:0] tag_q  [MAX_OUTSTANDING];

    logic                  redirect, req_fire, rsp_fire, push, pop;
    logic [WORD_WIDTH-1:0] target;

    function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TAW'(1);
    endfunction

    always_comb begin
        redirect       = (pc_sel == 2'b01) || (pc_sel == 2'b10);
        target         = ((pc_sel == 2'b10) ? jalr_tgt : jal_bxx_tgt) & ALIGN_MASK;
        // run_q keeps the request port quiet for the first cycle out of reset
        imem_req_valid = run_q && !redirect
                         && ((int'(count_q) + int'(out_q)) < DEPTH)
                         && (int'(out_q) < MAX_OUTSTANDING);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid;
        push           = rsp_fire && (drop_q == '0) && !redirect;
        valid          = (count_q != '0) && !redirect;
        pop            = valid && !bubble;
        pc             = valid ? q_pc_q[head_q] : '0;
        ir             = valid ? q_ir_q[head_q] : '0;

        out_d      = out_q + OW'(req_fire) - OW'(rsp_fire);
        tag_wr_d   = req_fire ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = rsp_fire ? tag_inc(tag_rd_q) : tag_rd_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        head_d     = pop  ? head_q + QAW'(1) : head_q;
        tail_d     = push ? tail_q + QAW'(1) : tail_q;
        drop_d     = drop_q;
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + WORD_WIDTH'(4);
        end
        if (redirect) begin
            fetch_pc_d = target;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_d     = out_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            run_q      <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            q_pc_q[tail_q] <= tag_q[tag_rd_q];
            q_ir_q[tail_q] <= imem_rsp_data;
        end
    end

    a_occupancy: assert property (@(posedge clk) disable iff (!resetn)
        int'(count_q) <= DEPTH);
    a_outstanding: assert property (@(posedge clk) disable iff (!resetn)
        int'(out_q) <= MAX_OUTSTANDING);
    a_drop: assert property (@(posedge clk) disable iff (!resetn)
        drop_q <= out_q);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!resetn)
        imem_rsp_valid |-> (out_q != '0));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!resetn)
        imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a configurable-latency in-order imem model.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        bubble;
    logic [1:0]  pc_sel;
    logic [31:0] jal_bxx_tgt, jalr_tgt;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid;
    logic [31:0] pc, ir;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    ifetch_queue #(
        .WORD_WIDTH(32), .RESET_PC(32'h100), .DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .resetn(resetn), .bubble(bubble), .pc_sel(pc_sel),
        .jal_bxx_tgt(jal_bxx_tgt), .jalr_tgt(jalr_tgt),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .valid(valid), .pc(pc), .ir(ir)
    );

    function automatic logic [31:0] ir_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    // imem: responds in order, each request lat cycles after acceptance; cleared by reset
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mq[$];

    initial begin
        int          t;
        bit          acc, fire;
        logic [31:0] acc_addr;
        req_t        r;
        t = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = resetn && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            fire     = resetn && imem_rsp_valid;
            @(posedge clk);
            #2;
            t++;
            if (!resetn) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (fire) mq.delete(0);
                if (acc) begin
                    r.addr = acc_addr;
                    r.due  = t - 1 + lat;
                    mq.push_back(r);
                end
                if (mq.size() > 0 && mq[0].due <= t) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ir_of(mq[0].addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each consumed instruction must be the next sequential pc with matching ir.
    task automatic run_mon(input int n, input bit must_valid, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (must_valid) chk({tag, "_valid"}, 32'(valid), 32'd1);
            if (valid && !bubble) begin
                chk({tag, "_pc"}, pc, exp_pc);
                chk({tag, "_ir"}, ir, ir_of(exp_pc));
                exp_pc += 32'd4;
            end
            tick();
        end
    endtask

    task automatic post_reset_start(input string tag);
        @(negedge clk);
        chk({tag, "_c0_req"}, 32'(imem_req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_c1_req"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_c1_addr"}, imem_req_addr, 32'h100);
        chk({tag, "_c1_valid"}, 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_c2_valid"}, 32'(valid), 32'd0);
        chk({tag, "_c2_addr"}, imem_req_addr, 32'h104);
        tick();
        exp_pc = 32'h100;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; bubble = 1'b0; pc_sel = 2'b00;
        jal_bxx_tgt = '0; jalr_tgt = '0; imem_req_ready = 1'b1; exp_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        resetn = 1'b1;

        // 1: reset start, 1-cycle imem, one instruction per cycle from cycle 3
        post_reset_start("t1");
        run_mon(8, 1'b1, "t1");

        // 2: bubble freezes head while queue fills to DEPTH credit
        bubble = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(valid), 32'd1);
            chk("t2_hold_pc", pc, 32'h120);
            chk("t2_hold_ir", ir, ir_of(32'h120));
            if (i == 0) chk("t2_req_addr0", imem_req_addr, 32'h128);
            if (i == 1) chk("t2_req_addr1", imem_req_addr, 32'h12C);
            if (i < 2) chk("t2_req_on", 32'(imem_req_valid), 32'd1);
            else       chk("t2_req_credit", 32'(imem_req_valid), 32'd0);
            tick();
        end
        bubble = 1'b0;
        exp_pc = 32'h120;
        run_mon(8, 1'b1, "t2");

        // 4: jalr redirect with low bits set, response lands in the redirect cycle
        pc_sel = 2'b10; jalr_tgt = 32'h303;
        @(negedge clk);
        chk("t4_r_req", 32'(imem_req_valid), 32'd0);
        chk("t4_r_valid", 32'(valid), 32'd0);
        tick();
        pc_sel = 2'b00;
        @(negedge clk);
        chk("t4_r1_req", 32'(imem_req_valid), 32'd1);
        chk("t4_r1_addr", imem_req_addr, 32'h300);
        chk("t4_r1_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_r2_valid", 32'(valid), 32'd0);
        chk("t4_r2_addr", imem_req_addr, 32'h304);
        tick();
        exp_pc = 32'h300;
        run_mon(6, 1'b1, "t4");

        // 3: 3-cycle imem, redirect to 0x200 with two fetches in flight
        pc_sel = 2'b01; jal_bxx_tgt = 32'h180;
        @(negedge clk);
        chk("t3_a_req", 32'(imem_req_valid), 32'd0);
        tick();
        pc_sel = 2'b00; lat = 3;
        @(negedge clk);
        chk("t3_a1_addr", imem_req_addr, 32'h180);
        chk("t3_a1_req", 32'(imem_req_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("t3_a2_addr", imem_req_addr, 32'h184);
        chk("t3_a2_req", 32'(imem_req_valid), 32'd1);
        tick();
        pc_sel = 2'b01; jal_bxx_tgt = 32'h200;
        @(negedge clk);
        chk("t3_a3_req", 32'(imem_req_valid), 32'd0);
        chk("t3_a3_valid", 32'(valid), 32'd0);
        tick();
        pc_sel = 2'b00;
        @(negedge clk);
        chk("t3_a4_req", 32'(imem_req_valid), 32'd0);
        chk("t3_a4_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_a5_req", 32'(imem_req_valid), 32'd1);
        chk("t3_a5_addr", imem_req_addr, 32'h200);
        chk("t3_a5_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_a6_addr", imem_req_addr, 32'h204);
        chk("t3_a6_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_a7_req", 32'(imem_req_valid), 32'd0);
        chk("t3_a7_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_a8_valid", 32'(valid), 32'd0);
        tick();
        exp_pc = 32'h200;
        run_mon(1, 1'b1, "t3_first");
        run_mon(11, 1'b0, "t3");

        // imem not ready for a few cycles: fetch address must not advance
        imem_req_ready = 1'b0;
        run_mon(4, 1'b0, "stall");
        imem_req_ready = 1'b1;
        run_mon(12, 1'b0, "stall_rel");

        // 5: fill under bubble, redirect while stalled, then wrap past 0xFFFF_FFFC
        bubble = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("t5_full_req", 32'(imem_req_valid), 32'd0);
        chk("t5_full_valid", 32'(valid), 32'd1);
        tick();
        pc_sel = 2'b01; jal_bxx_tgt = 32'hFFFF_FFF8;
        @(negedge clk);
        chk("t5_r_valid", 32'(valid), 32'd0);
        chk("t5_r_req", 32'(imem_req_valid), 32'd0);
        tick();
        pc_sel = 2'b00; bubble = 1'b0; lat = 1;
        @(negedge clk);
        chk("t5_r1_addr", imem_req_addr, 32'hFFFF_FFF8);
        chk("t5_r1_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_r2_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_r2_valid", 32'(valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_wrap_req", 32'(imem_req_valid), 32'd1);
        chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
        chk("t5_r3_pc", pc, 32'hFFFF_FFF8);
        chk("t5_r3_ir", ir, ir_of(32'hFFFF_FFF8));
        tick();
        exp_pc = 32'hFFFF_FFFC;
        run_mon(6, 1'b1, "t5");

        // 6: reset mid-stream with two requests outstanding and a valid head
        pc_sel = 2'b01; jal_bxx_tgt = 32'h600;
        tick();
        pc_sel = 2'b00; lat = 3; bubble = 1'b1;
        @(negedge clk);
        chk("t6_r1_addr", imem_req_addr, 32'h600);
        tick();
        @(negedge clk);
        chk("t6_r2_addr", imem_req_addr, 32'h604);
        tick();
        repeat (4) tick();
        chk("t6_pre_valid", 32'(valid), 32'd1);
        chk("t6_pre_pc", pc, 32'h600);
        chk("t6_pre_req", 32'(imem_req_valid), 32'd0);
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_pc", pc, 32'd0);
        chk("t6_rst_ir", ir, 32'd0);
        chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
        tick();
        tick();
        lat = 1; bubble = 1'b0;
        tick();
        resetn = 1'b1;
        post_reset_start("t6");
        run_mon(6, 1'b1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
